// File: rtl/robot_controller.sv
// robot_controller: left-hand wall follower with trash removal, home-return
// and trap detection for the pipe-cleaning robot.
// Optional feature macro: ROBOT_STEP_COUNT_EN adds a saturating forward-step
// counter output (step_count).
module robot_controller #(
  parameter int unsigned REMOVE_CYCLES = 3,
  parameter int unsigned MAX_SPINS     = 4,
  parameter int unsigned STEP_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              head,
  input  logic              left,
  input  logic              under,
  input  logic              barrier,
  output logic              front,
  output logic              turn,
  output logic              remove,
  output logic              done,
  output logic              stuck
`ifdef ROBOT_STEP_COUNT_EN
  ,
  output logic [STEP_W-1:0] step_count
`endif
);

  localparam int unsigned ROT_TURNS = 3;
  localparam int unsigned SPIN_W    = $clog2(MAX_SPINS + 1);
  localparam int unsigned PH_MAX    = (REMOVE_CYCLES > ROT_TURNS) ? REMOVE_CYCLES : ROT_TURNS;
  localparam int unsigned PH_W      = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_FOLLOW, S_FWD, S_ROTATE, S_REMOVE, S_DONE
  } state_e;

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [SPIN_W-1:0]   spin_q, spin_d;
  logic                left_home_q, left_home_d;
  logic                front_q, front_d;
  logic                turn_q, turn_d;
  logic                remove_q, remove_d;
  logic                done_q, done_d;
  logic                stuck_q, stuck_d;
`ifdef ROBOT_STEP_COUNT_EN
  logic [STEP_W-1:0]   step_q, step_d;
`endif

  // Next-state and registered-command decode.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    phase_d     = phase_q;
    spin_d      = spin_q;
    left_home_d = left_home_q;
    front_d     = 1'b0;
    turn_d      = 1'b0;
    remove_d    = 1'b0;
    done_d      = 1'b0;
    stuck_d     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_SEEK;

      S_SEEK, S_FOLLOW, S_FWD: begin
        if (under && left_home_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (barrier) begin
          // Trash ahead: remember where to resume; FWD resumes as FOLLOW.
          ret_d    = (state_q == S_FWD) ? S_FOLLOW : state_q;
          state_d  = S_REMOVE;
          remove_d = 1'b1;
          phase_d  = PH_W'(1);
        end else if (state_q == S_SEEK) begin
          if (left) begin
            state_d = S_FOLLOW;
          end else if (head) begin
            state_d = S_ROTATE;
            turn_d  = 1'b1;
            phase_d = PH_W'(1);
          end else begin
            front_d = 1'b1;
          end
        end else if (state_q == S_FOLLOW) begin
          if (!left) begin
            turn_d  = 1'b1;
            state_d = S_FWD;
          end else if (head) begin
            state_d = S_ROTATE;
            turn_d  = 1'b1;
            phase_d = PH_W'(1);
          end else begin
            front_d = 1'b1;
          end
        end else begin
          state_d = S_FOLLOW;
          front_d = !head;
        end
      end

      S_ROTATE: begin
        // Right turn as three left turns; sensors are not consulted.
        turn_d = 1'b1;
        if (phase_q == PH_W'(ROT_TURNS - 1)) begin
          phase_d = '0;
          spin_d  = (spin_q == SPIN_W'(MAX_SPINS)) ? spin_q : spin_q + SPIN_W'(1);
          state_d = (spin_d == SPIN_W'(MAX_SPINS)) ? S_DONE : S_FOLLOW;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_REMOVE: begin
        // Remove strobes, then one quiet cycle so the sensors refresh.
        if (phase_q < PH_W'(REMOVE_CYCLES)) begin
          remove_d = 1'b1;
          phase_d  = phase_q + PH_W'(1);
        end else begin
          phase_d = '0;
          state_d = ret_q;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        stuck_d = (spin_q == SPIN_W'(MAX_SPINS));
      end

      default: state_d = S_IDLE;
    endcase

    if (front_d) begin
      left_home_d = 1'b1;
      spin_d      = '0;
    end
  end

`ifdef ROBOT_STEP_COUNT_EN
  // Saturating count of forward moves.
  always_comb begin
    step_d = step_q;
    if (front_d && (step_q != {STEP_W{1'b1}})) step_d = step_q + STEP_W'(1);
  end
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ret_q       <= S_SEEK;
      phase_q     <= '0;
      spin_q      <= '0;
      left_home_q <= 1'b0;
      front_q     <= 1'b0;
      turn_q      <= 1'b0;
      remove_q    <= 1'b0;
      done_q      <= 1'b0;
      stuck_q     <= 1'b0;
`ifdef ROBOT_STEP_COUNT_EN
      step_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      phase_q     <= phase_d;
      spin_q      <= spin_d;
      left_home_q <= left_home_d;
      front_q     <= front_d;
      turn_q      <= turn_d;
      remove_q    <= remove_d;
      done_q      <= done_d;
      stuck_q     <= stuck_d;
`ifdef ROBOT_STEP_COUNT_EN
      step_q      <= step_d;
`endif
    end
  end

  assign front  = front_q;
  assign turn   = turn_q;
  assign remove = remove_q;
  assign done   = done_q;
  assign stuck  = stuck_q;
`ifdef ROBOT_STEP_COUNT_EN
  assign step_count = step_q;
`endif

endmodule

// File: tb/tb_robot_controller.sv
// Self-checking bench for robot_controller: directed scenarios plus random
// sensor traffic compared against a command-queue reference model.
module tb_robot_controller;

  localparam int RC = 3;
  localparam int MS = 4;
  localparam int IT_TURN = 1, IT_TURN_LAST = 2, IT_REM = 3, IT_GAP = 4;

  typedef enum int {M_IDLE, M_SEEK, M_FOLLOW, M_FWD, M_DONE} mode_t;

  logic clock;
  logic reset, head, left, under, barrier;
  logic front, turn, remove, done, stuck;
`ifdef ROBOT_STEP_COUNT_EN
  logic [15:0] step_count;
`endif

  int tests_run;
  int tests_failed;
  int cycle_no;

  // reference model state
  mode_t mode;
  int    q[$];
  bit    left_home;
  int    spins;
  bit    trapped;
  int    steps;
  bit    e_front, e_turn, e_remove, e_done, e_stuck;

  robot_controller #(.REMOVE_CYCLES(RC), .MAX_SPINS(MS), .STEP_W(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .head    (head),
    .left    (left),
    .under   (under),
    .barrier (barrier),
    .front   (front),
    .turn    (turn),
    .remove  (remove),
    .done    (done),
    .stuck   (stuck)
`ifdef ROBOT_STEP_COUNT_EN
    ,
    .step_count (step_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cycle_no, got, exp);
    end
  endtask

  // Begin a right turn: first turn now, two more queued, resume in FOLLOW.
  task automatic model_rotate();
    mode   = M_FOLLOW;
    e_turn = 1'b1;
    q.push_back(IT_TURN);
    q.push_back(IT_TURN_LAST);
  endtask

  task automatic model_step(input bit h, input bit l, input bit u, input bit b, input bit r);
    int it;
    e_front = 0; e_turn = 0; e_remove = 0; e_done = 0; e_stuck = 0;
    if (r) begin
      mode = M_IDLE; q.delete(); left_home = 0; spins = 0; trapped = 0; steps = 0;
      return;
    end
    if (q.size() > 0) begin
      it = q.pop_front();
      case (it)
        IT_TURN: e_turn = 1;
        IT_TURN_LAST: begin
          e_turn = 1;
          if (spins < MS) spins++;
          if (spins == MS) begin mode = M_DONE; trapped = 1; end
        end
        IT_REM: e_remove = 1;
        default: ;
      endcase
    end else begin
      case (mode)
        M_IDLE: mode = M_SEEK;
        M_DONE: begin e_done = 1; e_stuck = trapped; end
        default: begin
          if (u && left_home) begin
            mode = M_DONE; e_done = 1;
          end else if (b) begin
            if (mode == M_FWD) mode = M_FOLLOW;
            e_remove = 1;
            for (int i = 1; i < RC; i++) q.push_back(IT_REM);
            q.push_back(IT_GAP);
          end else if (mode == M_SEEK) begin
            if (l) mode = M_FOLLOW;
            else if (h) model_rotate();
            else e_front = 1;
          end else if (mode == M_FOLLOW) begin
            if (!l) begin e_turn = 1; mode = M_FWD; end
            else if (h) model_rotate();
            else e_front = 1;
          end else begin
            mode = M_FOLLOW;
            e_front = !h;
          end
        end
      endcase
    end
    if (e_front) begin left_home = 1; spins = 0; steps++; end
  endtask

  // Drive one robot cycle, advance the model, compare all outputs.
  task automatic cyc(input bit h, input bit l, input bit u, input bit b, input bit r);
    reset = r; head = h; left = l; under = u; barrier = b;
    @(posedge clock);
    model_step(h, l, u, b, r);
    #1;
    cycle_no++;
    check_eq("front", 32'(front), 32'(e_front));
    check_eq("turn", 32'(turn), 32'(e_turn));
    check_eq("remove", 32'(remove), 32'(e_remove));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("stuck", 32'(stuck), 32'(e_stuck));
    check_eq("onehot", 32'((32'(front) + 32'(turn) + 32'(remove)) <= 1), 32'd1);
`ifdef ROBOT_STEP_COUNT_EN
    check_eq("step_count", 32'(step_count), 32'(steps));
`endif
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  initial begin
    int n_turn;
    int n_front;
    tests_run = 0; tests_failed = 0; cycle_no = 0;
    mode = M_IDLE; left_home = 0; spins = 0; trapped = 0; steps = 0;
    reset = 1; head = 0; left = 0; under = 0; barrier = 0;

    // Reset then seek straight ahead.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check_eq("reset_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    check_eq("seek_front", 32'(front), 32'd1);

    // Right rotation from SEEK, sensors ignored during it, then FOLLOW.
    cyc(1, 0, 0, 0, 0);
    cyc(rb(), rb(), 0, rb(), 0);
    cyc(rb(), rb(), 0, rb(), 0);
    cyc(0, 1, 0, 0, 0);
    check_eq("rot_follow_front", 32'(front), 32'd1);

    // Left opening in FOLLOW.
    cyc(0, 0, 0, 0, 0);
    check_eq("open_turn", 32'(turn), 32'd1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);

    // Trash removal in FOLLOW, then resume.
    cyc(0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0);
    check_eq("rem_gap", 32'(remove), 32'd0);
    cyc(0, 1, 0, 0, 0);
    check_eq("rem_resume", 32'(front), 32'd1);

    // Reset during the second remove cycle aborts the removal.
    cyc(1, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 1);
    check_eq("rem_abort", 32'(remove), 32'd0);

    // Home: under held from reset is ignored until the first forward move.
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check_eq("home_done", 32'(done), 32'd1);
    for (int i = 0; i < 22; i++) cyc(rb(), rb(), rb(), rb(), 0);
    check_eq("home_hold", 32'(done), 32'd1);
    check_eq("home_stuck", 32'(stuck), 32'd0);

    // Trap: head and left held in FOLLOW -> four rotations then halt.
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    n_turn = 0; n_front = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 0, 0, 0);
      n_turn += int'(turn);
      n_front += int'(front);
    end
    check_eq("trap_turns", 32'(n_turn), 32'd12);
    check_eq("trap_fronts", 32'(n_front), 32'd0);
    check_eq("trap_done", 32'(done), 32'd1);
    check_eq("trap_stuck", 32'(stuck), 32'd1);

    // Random traffic.
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      cyc(rb(), rb(), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
